// File: rtl/rr_arbiter_8to3.sv
// Round-robin arbiter, 8 requesters, registered one-hot grant plus 8:3 encoded index.
// Optional hold timeout with forced rotation is enabled by defining RR_ARB_TIMEOUT_EN.
module rr_arbiter_8to3 #(
  parameter int unsigned MAX_HOLD  = 16,
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned PTR_RESET = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] idx_q, idx_d;

  logic [7:0] own;
  logic [2:0] search_start;
  logic [7:0] search_mask;
  logic       found;
  logic [2:0] found_idx;
  logic       timeout_hit;
  logic       new_grant;

  assign own = 8'b1 << idx_q;

  // While busy the search begins just past the owner with the owner masked out,
  // so a release (or forced rotation) always moves priority past it.
  always_comb begin
    search_start = (state_q == BUSY) ? idx_q + 3'd1 : ptr_q;
    search_mask  = (state_q == BUSY) ? (req & ~own) : req;
    found        = 1'b0;
    found_idx    = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      logic [2:0] pos;
      pos = search_start + 3'(k);
      if (!found && search_mask[pos]) begin
        found     = 1'b1;
        found_idx = pos;
      end
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_q;
  logic             preempt_q;

  assign timeout_hit = (state_q == BUSY) && (hold_q == CNT_W'(MAX_HOLD - 1)) &&
                       req[idx_q] && (|(req & ~own));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= timeout_hit;
      if (new_grant) begin
        hold_q <= '0;
      end else if (state_q == BUSY && hold_q != CNT_W'(MAX_HOLD - 1)) begin
        hold_q <= hold_q + 1'b1;
      end
    end
  end

  assign preempt = preempt_q;
`else
  logic unused_cfg;
  assign unused_cfg  = (MAX_HOLD > 0) ^ (CNT_W > 0);
  assign timeout_hit = 1'b0;
  assign preempt     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    new_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = BUSY;
          new_grant = 1'b1;
          idx_d     = found_idx;
          gnt_d     = 8'b1 << found_idx;
        end
      end
      BUSY: begin
        if (!req[idx_q] || timeout_hit) begin
          ptr_d = idx_q + 3'd1;
          if (found) begin
            new_grant = 1'b1;
            idx_d     = found_idx;
            gnt_d     = 8'b1 << found_idx;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'(PTR_RESET);
      gnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;

endmodule
